// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared control codes, FSM states and aluOp encodings for the sequential ALU.
package alu_seq_pkg;
  typedef enum logic [3:0] {
    ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, MUL, DIV, DIVU, REM, REMU, ILLEGAL
  } alu_ctrl_t;
  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational map from aluOp and instruction fields to an ALU control code.
module alu_ctrl_decode
  import alu_seq_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       funct7_0,
  input  logic       op_5,
  output alu_ctrl_t  ctrl,
  output logic       is_iterative
);
  alu_ctrl_t w_base, w_mext;
  always_comb begin
    case (funct3)
      3'b000:  w_base = (op_5 && funct7_5) ? SUB : ADD;
      3'b001:  w_base = SLL;
      3'b010:  w_base = SLT;
      3'b011:  w_base = SLTU;
      3'b100:  w_base = XOR;
      3'b101:  w_base = funct7_5 ? SRA : SRL;
      3'b110:  w_base = OR;
      default: w_base = AND;
    endcase
    case (funct3)
      3'b000:  w_mext = MUL;
      3'b100:  w_mext = DIV;
      3'b101:  w_mext = DIVU;
      3'b110:  w_mext = REM;
      3'b111:  w_mext = REMU;
      default: w_mext = ILLEGAL;
    endcase
  end
  assign ctrl = aluOp == ALUOP_ADD ? ADD :
                aluOp == ALUOP_SUB ? SUB :
                aluOp == ALUOP_ILL ? ILLEGAL :
                (op_5 && funct7_0) ? w_mext : w_base;
  assign is_iterative = ctrl inside {MUL, DIV, DIVU, REM, REMU};
endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered ALU with single-cycle base ops and iterative shift-add multiply
// and restoring divide behind a start/busy/done handshake.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      aluOp,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic            op_5,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  localparam int SW = $clog2(XLEN);
  alu_ctrl_t       w_ctrl, r_ctrl;
  logic            w_iter;
  state_t          r_state;
  logic [SW-1:0]   r_cnt;
  logic [XLEN-1:0] r_a, r_b, r_acc, r_result, w_alu, w_fix;
  logic            r_qneg, r_rneg, r_done, r_err;
  logic            w_sgn, w_na, w_nb, w_mul;
  logic [XLEN:0]   w_sh, w_diff;
  alu_ctrl_decode u_dec (
    .aluOp(aluOp), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
    .op_5(op_5), .ctrl(w_ctrl), .is_iterative(w_iter)
  );
  always_comb begin
    case (w_ctrl)
      ADD:     w_alu = srcA + srcB;
      SUB:     w_alu = srcA - srcB;
      AND:     w_alu = srcA & srcB;
      OR:      w_alu = srcA | srcB;
      XOR:     w_alu = srcA ^ srcB;
      SLT:     w_alu = XLEN'($signed(srcA) < $signed(srcB));
      SLTU:    w_alu = XLEN'(srcA < srcB);
      SLL:     w_alu = srcA << srcB[SW-1:0];
      SRL:     w_alu = srcA >> srcB[SW-1:0];
      SRA:     w_alu = $signed(srcA) >>> srcB[SW-1:0];
      default: w_alu = '0;
    endcase
  end
  assign w_sgn  = w_ctrl inside {DIV, REM};
  assign w_na   = w_sgn & srcA[XLEN-1];
  assign w_nb   = w_sgn & srcB[XLEN-1];
  assign w_mul  = r_ctrl == MUL;
  assign w_sh   = {r_acc, r_a[XLEN-1]};
  assign w_diff = w_sh - {1'b0, r_b};
  // Divide-by-zero naturally yields all-ones quotient and dividend remainder on magnitudes,
  // so only the quotient sign flip is suppressed; overflow needs no special handling.
  assign w_fix = w_mul ? r_acc :
                 (r_ctrl inside {REM, REMU}) ? (r_rneg ? -r_acc : r_acc) :
                 (r_qneg ? -r_a : r_a);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          if (w_iter) begin
            r_state <= ITER;
            r_ctrl  <= w_ctrl;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_a     <= w_na ? -srcA : srcA;
            r_b     <= w_nb ? -srcB : srcB;
            r_qneg  <= (w_na ^ w_nb) & (|srcB);
            r_rneg  <= w_na;
          end else begin
            r_result <= w_alu;
            r_err    <= w_ctrl == ILLEGAL;
            r_done   <= 1'b1;
          end
        end
        ITER: begin
          r_acc <= w_mul ? r_acc + (r_b[0] ? r_a : '0) :
                   (w_diff[XLEN] ? w_sh[XLEN-1:0] : w_diff[XLEN-1:0]);
          r_a   <= w_mul ? r_a << 1 : {r_a[XLEN-2:0], ~w_diff[XLEN]};
          r_b   <= w_mul ? r_b >> 1 : r_b;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == SW'(XLEN - 1)) r_state <= FIX;
        end
        FIX: begin
          r_result <= w_fix;
          r_err    <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy   = r_state != IDLE;
  assign done   = r_done;
  assign err    = r_err;
  assign result = r_result;
  assign zero   = r_result == '0;
endmodule
